// File: rtl/tlb_lookup_fill.sv
// ---------------------------------------------------------------------------
// tlb_lookup_fill
// Set-associative Sv32 TLB placed in front of the page-table walker.
// Translates fetch/load/store addresses from local storage. A miss raises a
// walk request that is held until the walker returns a fill or a fault. Fills
// go into a round-robin way, or into the way that already holds the page.
// Also forwards aborts to the walker and performs a set-by-set flush sweep.
//
// Ports
//   clk, rst                    clock, asynchronous active-low reset
//   translation_on              1 = Sv32, 0 = bare (identity mapping)
//   lookup_valid/vaddr/rnw/execute   translation request
//   lookup_done/paddr/fault     translation result
//   abort                       cancel the outstanding lookup
//   flush / flush_done          sfence.vma request / sweep complete pulse
//   mmu_request, mmu_virtual_address, mmu_rnw, mmu_execute   walk request
//   mmu_abort_request           cancel the walker's current walk
//   mmu_write_entry, mmu_is_fault, mmu_upper_physical_address  walk result
//
// State  | meaning
// IDLE   | serving lookups from storage (or bare mode)
// WALK   | miss outstanding, waiting for the walker
// FLUSH  | clearing one set per cycle
// ---------------------------------------------------------------------------
module tlb_lookup_fill #(
  parameter int DEPTH = 32,
  parameter int WAYS  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        translation_on,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_vaddr,
  input  logic        lookup_rnw,
  input  logic        lookup_execute,
  output logic        lookup_done,
  output logic [31:0] lookup_paddr,
  output logic        lookup_fault,
  input  logic        abort,
  input  logic        flush,
  output logic        flush_done,
  output logic        mmu_request,
  output logic [31:0] mmu_virtual_address,
  output logic        mmu_rnw,
  output logic        mmu_execute,
  output logic        mmu_abort_request,
  input  logic        mmu_write_entry,
  input  logic        mmu_is_fault,
  input  logic [19:0] mmu_upper_physical_address
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = 20 - IDX_W;
  localparam int RR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_WALK  = 3'b010,
    S_FLUSH = 3'b100
  } state_t;

  state_t           r_state;
  logic [WAYS-1:0]  r_valid    [DEPTH];
  logic [WAYS-1:0]  r_store_ok [DEPTH];
  logic [TAG_W-1:0] r_tag      [WAYS][DEPTH];
  logic [19:0]      r_ppn      [WAYS][DEPTH];
  logic [RR_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0] r_flush_cnt;
  logic             r_mmu_request;
  logic [31:0]      r_mmu_vaddr;
  logic             r_mmu_rnw;
  logic             r_mmu_execute;

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [IDX_W-1:0] w_fill_idx;
  logic [TAG_W-1:0] w_fill_tag;
  logic             w_is_store;
  logic [WAYS-1:0]  w_tag_match;
  logic [WAYS-1:0]  w_hit_vec;
  logic             w_hit;
  logic [19:0]      w_hit_ppn;
  logic [RR_W-1:0]  w_fill_way;
  logic             w_idle;
  logic             w_walk;
  logic             w_flushing;
  logic             w_miss;
  logic             w_walk_live;
  logic             w_fill;
  logic             w_fault;
  logic             w_flush_last;

  assign w_lk_idx   = lookup_vaddr[12 +: IDX_W];
  assign w_lk_tag   = lookup_vaddr[31 -: TAG_W];
  assign w_fill_idx = r_mmu_vaddr[12 +: IDX_W];
  assign w_fill_tag = r_mmu_vaddr[31 -: TAG_W];
  assign w_is_store = ~lookup_rnw & ~lookup_execute;

  // A tag match alone is what must be unique; store_ok only gates the hit.
  always_comb begin
    w_tag_match = '0;
    w_hit_vec   = '0;
    w_hit_ppn   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_lk_idx][w] && (r_tag[w][w_lk_idx] == w_lk_tag)) begin
        w_tag_match[w] = 1'b1;
        if (!w_is_store || r_store_ok[w_lk_idx][w]) begin
          w_hit_vec[w] = 1'b1;
          w_hit_ppn    = r_ppn[w][w_lk_idx];
        end
      end
    end
  end

  assign w_hit = |w_hit_vec;

  // Refill the way already holding this page so a store fill upgrades a
  // load entry instead of creating a duplicate.
  always_comb begin
    w_fill_way = r_rr_ptr;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_fill_idx][w] && (r_tag[w][w_fill_idx] == w_fill_tag)) begin
        w_fill_way = RR_W'(w);
      end
    end
  end

  assign w_idle       = (r_state == S_IDLE);
  assign w_walk       = (r_state == S_WALK);
  assign w_flushing   = (r_state == S_FLUSH);
  assign w_miss       = w_idle & lookup_valid & translation_on & ~w_hit & ~abort & ~flush;
  assign w_walk_live  = w_walk & ~abort & ~flush;
  assign w_fill       = w_walk_live & mmu_write_entry;
  assign w_fault      = w_walk_live & mmu_is_fault & ~mmu_write_entry;
  assign w_flush_last = w_flushing & (r_flush_cnt == IDX_W'(DEPTH - 1));

  assign lookup_done  = w_idle & lookup_valid & ~abort & ~flush & (~translation_on | w_hit);
  assign lookup_paddr = translation_on ? {w_hit_ppn, lookup_vaddr[11:0]} : lookup_vaddr;
  assign lookup_fault = w_fault;
  assign flush_done   = w_flush_last;
  assign mmu_abort_request   = w_walk & (abort | flush);
  assign mmu_request         = r_mmu_request;
  assign mmu_virtual_address = r_mmu_vaddr;
  assign mmu_rnw             = r_mmu_rnw;
  assign mmu_execute         = r_mmu_execute;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_flush_cnt   <= '0;
      r_mmu_request <= 1'b0;
      r_mmu_vaddr   <= '0;
      r_mmu_rnw     <= 1'b0;
      r_mmu_execute <= 1'b0;
      for (int s = 0; s < DEPTH; s++) begin
        r_valid[s]    <= '0;
        r_store_ok[s] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_state     <= S_FLUSH;
            r_flush_cnt <= '0;
          end else if (w_miss) begin
            r_state       <= S_WALK;
            r_mmu_request <= 1'b1;
            r_mmu_vaddr   <= lookup_vaddr;
            r_mmu_rnw     <= lookup_rnw;
            r_mmu_execute <= lookup_execute;
          end
        end
        S_WALK: begin
          if (flush) begin
            r_state       <= S_FLUSH;
            r_flush_cnt   <= '0;
            r_mmu_request <= 1'b0;
          end else if (abort) begin
            r_state       <= S_IDLE;
            r_mmu_request <= 1'b0;
          end else if (mmu_write_entry) begin
            r_valid[w_fill_idx][w_fill_way]    <= 1'b1;
            r_store_ok[w_fill_idx][w_fill_way] <= ~r_mmu_rnw & ~r_mmu_execute;
            r_rr_ptr      <= (r_rr_ptr == RR_W'(WAYS - 1)) ? '0 : r_rr_ptr + 1'b1;
            r_state       <= S_IDLE;
            r_mmu_request <= 1'b0;
          end else if (mmu_is_fault) begin
            r_state       <= S_IDLE;
            r_mmu_request <= 1'b0;
          end
        end
        S_FLUSH: begin
          r_valid[r_flush_cnt]    <= '0;
          r_store_ok[r_flush_cnt] <= '0;
          if (w_flush_last) begin
            r_state     <= S_IDLE;
            r_flush_cnt <= '0;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag/PPN payload needs no reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fill_way][w_fill_idx] <= w_fill_tag;
      r_ppn[w_fill_way][w_fill_idx] <= mmu_upper_physical_address;
    end
  end

  a_single_way_match: assert property (@(posedge clk) disable iff (!rst)
    (w_idle && lookup_valid && translation_on) |-> $onehot0(w_tag_match));

  a_valid_held_in_walk: assert property (@(posedge clk) disable iff (!rst)
    (w_walk && !lookup_valid) |-> (abort || flush));

endmodule

// File: doc/tlb_lookup_fill.md
Name: tlb_lookup_fill

Overview:
- Set-associative Sv32 translation lookaside buffer sitting directly upstream of the page-table walker.
- Serves fetch or load/store address translation from local storage.
- On a miss, raises a walk request to the walker and holds it until the walker returns either a fill or a fault.
- Writes the returned translation into a round-robin-selected way; also provides abort forwarding and a swept flush.

Parameters:
- DEPTH, 32, number of sets; power of two, at least 2; IDX_W = log2(DEPTH).
- WAYS, 2, associativity; power of two, at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- translation_on  in  1  satp mode is Sv32; 0 = bare (identity mapping).
- lookup_valid  in  1  translation request; held with stable fields until lookup_done or lookup_fault, or until abort.
- lookup_vaddr  in  32  virtual address.
- lookup_rnw  in  1  load (1) / store (0); ignored when lookup_execute=1.
- lookup_execute  in  1  instruction fetch.
- lookup_done  out  1  translation valid this cycle.
- lookup_paddr  out  32  physical address; valid with lookup_done.
- lookup_fault  out  1  one-cycle page-fault pulse.
- abort  in  1  cancel the outstanding lookup.
- flush  in  1  sfence.vma request; single-cycle pulse.
- flush_done  out  1  one-cycle pulse when the sweep completes.
- mmu_request  out  1  walk request to the walker.
- mmu_virtual_address  out  32  registered copy of lookup_vaddr.
- mmu_rnw  out  1  registered lookup_rnw.
- mmu_execute  out  1  registered lookup_execute.
- mmu_abort_request  out  1  cancels the walker's current walk.
- mmu_write_entry  in  1  walk succeeded (one-cycle pulse).
- mmu_is_fault  in  1  walk faulted (one-cycle pulse).
- mmu_upper_physical_address  in  20  PPN returned by the walker; valid with mmu_write_entry.

Behaviour:
- Entry contents: valid, store_ok, tag = vaddr[31:12+IDX_W], ppn[19:0]. Set index = vaddr[12+IDX_W-1:12].
- Reset (rst low, asynchronous):
  - All valid and store_ok bits cleared; state = IDLE; round-robin pointer = 0.
  - Outputs lookup_done, lookup_fault, flush_done, mmu_request, mmu_abort_request = 0.
  - mmu_virtual_address = 0.
- States: IDLE, WALK, FLUSH. Encoding is one-hot.
- Bare mode (translation_on=0): in IDLE, lookup_done = lookup_valid combinationally and lookup_paddr = lookup_vaddr. No storage access, no walk.
- Hit path, IDLE, translation_on=1: a hit requires all of:
  - valid=1 and the tag matches in some way;
  - the access is a load or a fetch, or store_ok=1.
  - On a hit: lookup_done=1 in the same cycle (combinational) and lookup_paddr = {ppn, vaddr[11:0]}. A multi-way match is illegal; a simulation assertion is required.
- Miss path:
  - IDLE with lookup_valid and no hit: register vaddr/rnw/execute onto the mmu_* outputs and go to WALK.
  - mmu_request is a registered output: 1 in the cycle after the miss, held high throughout WALK.
- WALK exits:
  - mmu_write_entry: write the entry {valid=1, store_ok = ~mmu_rnw & ~mmu_execute, tag, ppn} into way rr_ptr of the indexed set; if that set already holds a valid matching tag, overwrite that way instead. Advance rr_ptr (wraps at WAYS-1). Go to IDLE; the retried lookup hits one cycle after the fill. A store fill overwrites a matching load entry, setting store_ok.
  - mmu_is_fault: lookup_fault=1 for exactly that cycle; nothing written; go to IDLE.
- Abort:
  - In WALK: mmu_abort_request=1 combinationally in the same cycle; go to IDLE. A coincident mmu_write_entry or mmu_is_fault is ignored: no fill, no fault pulse.
  - In IDLE: no effect.
  - lookup_done and lookup_fault are masked while abort=1.
- Flush:
  - flush in IDLE or WALK enters FLUSH. If taken from WALK, mmu_abort_request=1 in that cycle.
  - FLUSH sweeps an IDX_W-bit counter from 0 to DEPTH-1, clearing all ways of one set per cycle. flush_done is pulsed on the final set, then the block returns to IDLE.
  - Total FLUSH duration is exactly DEPTH cycles. lookup_done=0 throughout, and any mmu_write_entry is ignored.
  - flush asserted during FLUSH is ignored.
- Simultaneous flush and hit in IDLE: flush wins; lookup_done=0.
- mmu_request and lookup_valid drop together only through abort or flush. A simulation assertion checks that lookup_valid is not deasserted during WALK without abort.

Test Plan:
- Bare mode: translation_on=0, vaddr 0x8000_1234 load. Required: lookup_done in the same cycle, paddr 0x8000_1234, mmu_request never asserted.
- Cold load miss: vaddr 0x0040_3ABC. Required: mmu_request high from cycle+1. Walker returns write_entry with PPN 0x12345 at cycle+6. Then IDLE, lookup_done at cycle+7 with paddr 0x1234_5ABC.
- Store after load fill, same page: required to miss and walk with mmu_rnw=0. After the fill, store_ok=1 and the next store and load both hit.
- Walker fault: mmu_is_fault at cycle+4. Required: lookup_fault for exactly 1 cycle, nothing written. A repeated lookup of the same address walks again.
- Replacement, WAYS=2: fill pages 0x00000, 0x00020, 0x00040 (same set 0). Required: the third fill evicts 0x00000; 0x00020 and 0x00040 still hit.
- Abort coincident with write_entry: required mmu_abort_request=1, no fill, next lookup of the same page misses.
- Flush, DEPTH=32: issue flush during WALK. Required: mmu_abort_request pulse, flush_done exactly 32 cycles later, all previously filled pages miss.
